// File: rtl/fft_pair_feeder_pkg.sv
// fft_pair_feeder_pkg: shared widths, complex field helpers and the stage state enum.
package fft_pair_feeder_pkg;
  localparam int DATA_W = 24;
  localparam int HALF_W = DATA_W / 2;
  typedef enum logic {FILL, PAIR} state_t;
  function automatic logic [HALF_W-1:0] re(input logic [DATA_W-1:0] x);
    return x[DATA_W-1:HALF_W];
  endfunction
  function automatic logic [HALF_W-1:0] im(input logic [DATA_W-1:0] x);
    return x[HALF_W-1:0];
  endfunction
endpackage

// File: rtl/fft_pair_feeder_pair_buffer_mem.sv
// pair_buffer_mem: first-half sample store, one write port, asynchronous read, no reset.
module pair_buffer_mem #(
  parameter int W = 24,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_pair_feeder.sv
// fft_pair_feeder: radix-2 DIF pair former, emits x[k] with x[k+N/2] as second-half samples arrive.
module fft_pair_feeder
  import fft_pair_feeder_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int LOG2N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sof,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic         out_valid,
  output logic         out_first,
  output logic         out_last,
  output logic         frame_err
);
  localparam int N = 1 << LOG2N;
  localparam int H = N / 2;
  localparam int AW = (LOG2N > 1) ? LOG2N - 1 : 1;
  logic [LOG2N-1:0] idx;
  logic synced, accept, we;
  logic [AW-1:0] waddr, raddr;
  logic [W-1:0] rdata;
  state_t st;
  assign st = idx[LOG2N-1] ? PAIR : FILL;
  // synced means "inside a frame"; it drops on wrap so every frame needs its own in_sof
  assign accept = in_valid & (in_sof | synced);
  assign we = accept & (in_sof | st == FILL);
  assign waddr = in_sof ? '0 : AW'(idx);
  assign raddr = AW'(idx - LOG2N'(H));
  pair_buffer_mem #(.W(W), .DEPTH(H), .AW(AW)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .wdata(in_data), .raddr(raddr), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx <= '0;
      synced <= 1'b0;
      A <= '0;
      B <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      frame_err <= 1'b0;
      if (accept) begin
        if (in_sof) begin
          idx <= LOG2N'(1);
          synced <= 1'b1;
          frame_err <= idx != '0;
        end else begin
          idx <= idx + LOG2N'(1);
          if (st == PAIR) begin
            A <= rdata;
            B <= in_data;
            out_valid <= 1'b1;
            out_first <= idx == LOG2N'(H);
            out_last <= idx == LOG2N'(N - 1);
            synced <= idx != LOG2N'(N - 1);
          end
        end
      end
    end
endmodule

// File: tb/tb_fft_pair_feeder.sv
// tb_fft_pair_feeder: table-driven directed vectors plus a reset-mid-pair sequence.
module tb_fft_pair_feeder;
  logic clk = 0, reset = 0, in_valid = 0, in_sof = 0;
  logic [23:0] in_data = '0, A, B;
  logic out_valid, out_first, out_last, frame_err;
  int total = 0, bad = 0, row = 0;
  logic [23:0] ha = '0, hb = '0;
  typedef struct {
    logic v, s;
    logic [23:0] d;
    logic ev, ef, el, ee;
    logic [23:0] ea, eb;
  } vec_t;
  vec_t q[$];

  fft_pair_feeder dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .A(A), .B(B), .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] smp(input int base, input int i);
    int v = base + i;
    logic [11:0] r = 12'(v);
    logic [11:0] m = 12'(-v);
    return {r, m};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d t=%0t got=%h want=%h", n, row, $time, act, exp);
    end
  endtask

  task automatic push(input logic v, input logic s, input logic [23:0] d, input logic ev,
                      input logic ef, input logic el, input logic ee,
                      input logic [23:0] ea, input logic [23:0] eb);
    vec_t r;
    if (ev) begin
      ha = ea;
      hb = eb;
    end
    r.v = v; r.s = s; r.d = d; r.ev = ev; r.ef = ef; r.el = el; r.ee = ee;
    r.ea = ha; r.eb = hb;
    q.push_back(r);
  endtask

  task automatic push_frame(input int base, input int lo, input int hi, input bit gap, input bit err);
    for (int i = lo; i <= hi; i++) begin
      push(1, i == 0, smp(base, i), i >= 8, i == 8, i == 15, err && i == lo,
           smp(base, i - 8), smp(base, i));
      if (gap) push(0, i == 3, 24'hABCDEF, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic drop(input int base, input int n);
    for (int j = 0; j < n; j++) push(1, 0, smp(base, j), 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_table();
    foreach (q[i]) begin
      @(negedge clk);
      in_valid = q[i].v;
      in_sof = q[i].s;
      in_data = q[i].d;
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(q[i].ev));
      chk("out_first", 32'(out_first), 32'(q[i].ef));
      chk("out_last", 32'(out_last), 32'(q[i].el));
      chk("frame_err", 32'(frame_err), 32'(q[i].ee));
      chk("A", 32'(A), 32'(q[i].ea));
      chk("B", 32'(B), 32'(q[i].eb));
      row++;
    end
    q.delete();
    in_valid = 0;
    in_sof = 0;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_valid"}, 32'(out_valid), 0);
    chk({n, "_first"}, 32'(out_first), 0);
    chk({n, "_last"}, 32'(out_last), 0);
    chk({n, "_err"}, 32'(frame_err), 0);
    chk({n, "_A"}, 32'(A), 0);
    chk({n, "_B"}, 32'(B), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1;
    chk("first_pair_B", 32'(smp(0, 8)), 32'h008FF8);
    drop(500, 3);
    push_frame(0, 0, 15, 0, 0);
    push_frame(32, 0, 15, 0, 0);
    push_frame(64, 0, 15, 1, 0);
    drop(300, 4);
    push_frame(96, 0, 4, 0, 0);
    push_frame(128, 0, 15, 0, 1);
    push_frame(160, 0, 10, 0, 0);
    push_frame(192, 0, 15, 0, 1);
    push_frame(224, 0, 10, 0, 0);
    run_table();
    @(negedge clk);
    #2 reset = 0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset = 1;
    ha = '0;
    hb = '0;
    drop(400, 2);
    push_frame(16, 0, 15, 0, 0);
    run_table();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_pair_feeder.md
Name: fft_pair_feeder

Overview:
- Radix-2 DIF pair-forming stage that sits directly upstream of the 24-bit packed-complex butterfly.
- Accepts a stream of complex samples, N per frame.
- Stores the first N/2 samples of each frame. As each sample of the second half arrives, it emits that sample paired with its stored partner, x[k] and x[k+N/2], on registered A/B outputs.
- No backpressure: the butterfly consumes every cycle, so this block has no ready signal in either direction.

Parameters:
- W, 24, packed complex width: real part in [W-1:W/2], imag part in [W/2-1:0], each two's complement.
- LOG2N, 4, log2 of frame length N (N=16, N/2=8 storage entries); legal range 1..10.

Ports:
- clk  input  1  stage clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  W  incoming packed complex sample.
- in_valid  input  1  in_data is valid this cycle.
- in_sof  input  1  start of frame; qualified by in_valid; marks sample index 0.
- A  output  W  first butterfly operand, x[k] (registered).
- B  output  W  second butterfly operand, x[k+N/2] (registered).
- out_valid  output  1  A/B hold a valid pair.
- out_first  output  1  pair k=0 of the frame.
- out_last  output  1  pair k=N/2-1 of the frame.
- frame_err  output  1  one-cycle pulse: frame aborted by an early in_sof.

Behaviour:
- Reset: clk and reset as stated above (reset asynchronous, active-low).
  - While reset=0, A=0, B=0, out_valid=0, out_first=0, out_last=0, frame_err=0.
  - Index counter is 0, state is FILL and the synced flag is cleared.
  - Storage contents are don't-care and need no reset.
- Sync: a frame begins only on in_valid&in_sof.
  - After reset, samples with in_valid=1 and in_sof=0 are dropped until the first in_sof.
  - Dropped samples do not raise frame_err.
- Index counter idx has LOG2N bits and advances only on accepted samples (in_valid=1 while synced). in_valid=0 cycles hold all state; gaps are allowed anywhere.
- FILL state (idx < N/2):
  - An accepted sample is written to mem[idx].
  - idx increments.
  - out_valid=0 next cycle.
- PAIR state (idx >= N/2):
  - An accepted sample drives, on the next edge: A<=mem[idx-N/2], B<=in_data, out_valid<=1.
  - out_first<=(idx==N/2), out_last<=(idx==N-1).
- Latency: pair visible 1 cycle after the second-half sample is accepted. The butterfly adds 2 more cycles; the downstream valid tracker delays out_valid by 2.
- Wrap: after idx==N-1 is accepted, idx returns to 0 and the state returns to FILL. The next accepted sample must carry in_sof; otherwise it is dropped and the block desyncs until the next in_sof.
- Early in_sof: in_valid&in_sof with idx!=0 (mid-frame) does three things.
  - It aborts the current frame.
  - It pulses frame_err for 1 cycle.
  - It stores the sample as mem[0] with idx<=1. No pair is emitted for the aborted frame.
- Simultaneous: in_sof on the cycle where idx wraps to 0 is normal, not an error.
- out_valid, out_first and out_last are 0 on every cycle without a pair emission. A and B hold their last values when out_valid=0.
- Data is passed bit-exact: no arithmetic and no width change. Sign extension and halving are the butterfly's job.
- Reset asserted mid-frame clears everything immediately (asynchronous). The partial frame is discarded and in_sof is required again.

Decomposition:
- Shared package holds:
  - W and half-width constants.
  - re/im field-extract functions.
  - State enum {FILL, PAIR}. PAIR is derived from the idx MSB; the enum is used for debug and assertions.
- Sub-module pair_buffer_mem: N/2 x W register file, 1 write port, 1 asynchronous read port, no reset. The top level holds the counter, sync and error logic, and the output registers.

Test Plan:
- Basic frame: N=16, in_sof on sample 0, in_data[i]={12'(i),12'(-i)}, i=0..15, continuous valid.
  - No output for samples 0..7.
  - 8 consecutive out_valid cycles, starting 1 cycle after sample 8 is accepted, with A=x[k], B=x[k+8]; first pair A=0x000000, B=0x008FF8.
  - out_first on k=0, out_last on k=7.
- Gapped input: the same frame with in_valid toggling 1,0,1,0 -> identical pair sequence, out_valid only in cycles following accepted second-half samples, A/B held during gaps.
- Back-to-back frames: two frames, the second's in_sof on the cycle after sample 15 -> 16 pairs, no frame_err, pairs of frame 2 use frame-2 data only.
- Early sof: in_sof at sample 5 of a frame -> frame_err=1 for exactly 1 cycle, no pairs from the aborted frame, the new frame pairs correctly.
- Unsynced / missing sof: 3 samples without in_sof after reset, then a frame -> the 3 samples are dropped. A frame not followed by in_sof drops data until the next in_sof, with no out_valid.
- Reset mid-PAIR: assert reset after 3 pairs -> all outputs 0 immediately, without a clock edge. After release, the block needs in_sof before producing any output.
